// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;

  // Default word length in bits.
  localparam int unsigned DefaultDataW = 8;

  // Default synchronizer depth for SCK, CS and MOSI.
  localparam int unsigned DefaultSyncStages = 2;

  // Fill bit for the word sent when no transmit word is queued (all ones).
  localparam logic DefaultTxBit = 1'b1;

  // Frame state: IDLE outside a frame, ACTIVE while chip select is asserted.
  typedef enum logic [0:0] {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized value.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              dly_q;
  logic              sync_s;

  assign sync_s = sync_q[Stages-1];

  // Synchronizer chain plus a one-cycle-delayed copy of its output for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      dly_q  <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      dly_q  <= sync_s;
    end
  end

  // Edge pulses compare the synchronized level against its delayed copy.
  always_comb begin
    rise_o = sync_s & ~dly_q;
    fall_o = ~sync_s & dly_q;
  end

endmodule

// File: rtl/spi_responder.sv
// SPI mode-3 responder: oversampled SCK/CS/MOSI, MSB-first shift registers, a one-word
// transmit holding register and a parallel receive output.
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = DefaultDataW,
  parameter int unsigned       SYNC_STAGES = DefaultSyncStages,
  parameter logic [DATA_W-1:0] TX_DEFAULT  = {DATA_W{DefaultTxBit}}
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o,
  output logic              busy_o
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_state_e        state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-2:0] tx_shift_q;
  logic [DATA_W-2:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              miso_q;
  logic              oe_q;
  logic              underrun_q;
  logic              abort_q;

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;

  logic              cs_edge;
  logic              sck_act_fall;
  logic              sck_act_rise;
  logic              word_start;
  logic [DATA_W-1:0] tx_src;
  logic [DATA_W-1:0] rx_word;

  // SCK resets to its idle-high level. CS resets low so that a CS still held low when reset
  // releases produces no falling edge: a new frame needs a genuine CS falling edge.
  spi_sync_edge #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b1)
  ) u_sck_sync (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .d_i   (spi_clk_i),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_sync_edge #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b0)
  ) u_cs_sync (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .d_i   (spi_cs_i),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  // MOSI needs only the level, delayed by the same depth as SCK so they stay aligned.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Qualified SCK events: only in ACTIVE, and dropped when a CS edge lands in the same cycle.
  always_comb begin
    cs_edge      = cs_rise | cs_fall;
    sck_act_fall = (state_q == StActive) && !cs_edge && sck_fall;
    sck_act_rise = (state_q == StActive) && !cs_edge && sck_rise;
    word_start   = sck_act_fall && (bit_cnt_q == '0);
    tx_src       = hold_full_q ? hold_q : TX_DEFAULT;
    rx_word      = {rx_shift_q, mosi_s};
  end

  // Holding register: consumption at word start takes priority; a load is accepted only when
  // the register was empty at the start of the cycle, so a load racing an empty word start
  // is kept for the next word.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (word_start && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (tx_load_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  // Holding register state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Frame FSM with shift registers and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StActive;
            bit_cnt_q <= '0;
            oe_q      <= 1'b1;
          end
        end
        StActive: begin
          if (cs_rise) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            oe_q      <= 1'b0;
            abort_q   <= (bit_cnt_q != '0);
          end else begin
            if (sck_act_fall) begin
              if (bit_cnt_q == '0) begin
                // Word start: MSB goes out now, the remaining bits wait in tx_shift.
                miso_q     <= tx_src[DATA_W-1];
                tx_shift_q <= tx_src[DATA_W-2:0];
                underrun_q <= ~hold_full_q;
              end else begin
                miso_q     <= tx_shift_q[DATA_W-2];
                tx_shift_q <= tx_shift_q << 1;
              end
            end
            if (sck_act_rise) begin
              rx_shift_q <= rx_word[DATA_W-2:0];
              if (bit_cnt_q == LastBit) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
                bit_cnt_q  <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output assignments.
  always_comb begin
    spi_miso_o    = miso_q;
    spi_miso_oe_o = oe_q;
    rx_data_o     = rx_data_q;
    rx_valid_o    = rx_valid_q;
    tx_ready_o    = ~hold_full_q;
    tx_underrun_o = underrun_q;
    frame_abort_o = abort_q;
    busy_o        = (state_q == StActive);
  end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: table-driven single-word frames plus hand-written
// sequences for back-to-back words, abort, double load and reset mid-frame.
module tb_spi_responder;

  localparam int H = 6;  // SCK half period and CS setup/hold, in sys_clk cycles

  logic       sys_clk;
  logic       sys_rst_n;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_abort;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  int         und_cnt = 0;
  int         abort_cnt = 0;

  spi_responder #(
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .TX_DEFAULT (8'hFF)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .spi_clk_i    (spi_clk),
    .spi_cs_i     (spi_cs),
    .spi_mosi_i   (spi_mosi),
    .spi_miso_o   (spi_miso),
    .spi_miso_oe_o(spi_miso_oe),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .tx_data_i    (tx_data),
    .tx_load_i    (tx_load),
    .tx_ready_o   (tx_ready),
    .tx_underrun_o(tx_underrun),
    .frame_abort_o(frame_abort),
    .busy_o       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Pulse monitors, sampled on the inactive edge; a stuck pulse counts once per cycle.
  always @(negedge sys_clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_underrun) und_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge sys_clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge sys_clk);
    tx_load = 1'b0;
  endtask

  // Initiator side of mode 3: drive MOSI with SCK falling, sample MISO just before SCK rises.
  task automatic send_bits(input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_clk  = 1'b0;
      spi_mosi = w[7-i];
      wait_clks(H);
      got     = {got[6:0], spi_miso};
      spi_clk = 1'b1;
      wait_clks(H);
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clks(H);
    check("busy_in_frame", busy, 1'b1);
    check("oe_in_frame", spi_miso_oe, 1'b1);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    wait_clks(H);
  endtask

  function automatic logic [7:0] rx_at(input int idx);
    if (idx < rxq.size()) return rxq[idx];
    return 8'hxx;
  endfunction

  typedef struct {
    logic       do_load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] got;
    logic [7:0] got2;
    int         u0;
    int         a0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h01, 8'h01, 8'hFF, 1};
    vecs[2] = '{1'b1, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 0};
    vecs[3] = '{1'b1, 8'h80, 8'h7E, 8'h7E, 8'h80, 0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1};

    sys_rst_n = 1'b0;
    spi_clk   = 1'b1;
    spi_cs    = 1'b1;
    spi_mosi  = 1'b0;
    tx_data   = '0;
    tx_load   = 1'b0;
    wait_clks(3);
    sys_rst_n = 1'b1;
    wait_clks(H);

    // Reset state.
    check("rst_busy", busy, 1'b0);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_ready", tx_ready, 1'b1);

    // SCK toggling with CS high is ignored.
    for (int i = 0; i < 10; i++) begin
      spi_clk = ~spi_clk;
      wait_clks(H);
    end
    check("idle_busy", busy, 1'b0);
    check("idle_oe", spi_miso_oe, 1'b0);
    check("idle_rx_cnt", rxq.size(), 0);
    check("idle_tx_ready", tx_ready, 1'b1);
    check("idle_und_cnt", und_cnt, 0);

    // Table: one word per frame.
    foreach (vecs[k]) begin
      rxq.delete();
      u0 = und_cnt;
      a0 = abort_cnt;
      if (vecs[k].do_load) begin
        load_tx(vecs[k].tx);
        check("ready_after_load", tx_ready, 1'b0);
      end
      cs_low();
      send_bits(vecs[k].mosi, 8, got);
      cs_high();
      check("vec_rx_cnt", rxq.size(), 1);
      check("vec_rx_data", rx_at(0), vecs[k].exp_rx);
      check("vec_miso", got, vecs[k].exp_miso);
      check("vec_underrun", und_cnt - u0, vecs[k].exp_und);
      check("vec_tx_ready", tx_ready, 1'b1);
      check("vec_no_abort", abort_cnt - a0, 0);
      check("vec_oe_off", spi_miso_oe, 1'b0);
    end

    // Two back-to-back words in one frame, nothing queued.
    rxq.delete();
    u0 = und_cnt;
    cs_low();
    send_bits(8'h01, 8, got);
    send_bits(8'h80, 8, got2);
    cs_high();
    check("b2b_rx_cnt", rxq.size(), 2);
    check("b2b_rx0", rx_at(0), 8'h01);
    check("b2b_rx1", rx_at(1), 8'h80);
    check("b2b_miso0", got, 8'hFF);
    check("b2b_miso1", got2, 8'hFF);
    check("b2b_underruns", und_cnt - u0, 2);

    // CS raised after 5 bits: abort, no word; then a clean frame.
    rxq.delete();
    a0 = abort_cnt;
    cs_low();
    send_bits(8'hA8, 5, got);
    cs_high();
    check("abort_pulse", abort_cnt - a0, 1);
    check("abort_no_rx", rxq.size(), 0);
    check("abort_busy", busy, 1'b0);
    cs_low();
    send_bits(8'h55, 8, got);
    cs_high();
    check("after_abort_rx_cnt", rxq.size(), 1);
    check("after_abort_rx", rx_at(0), 8'h55);
    check("after_abort_no_abort", abort_cnt - a0, 1);

    // Second load while full is dropped; next word sends the first, the one after is default.
    load_tx(8'h11);
    load_tx(8'h22);
    check("dbl_ready", tx_ready, 1'b0);
    cs_low();
    send_bits(8'h00, 8, got);
    send_bits(8'h00, 8, got2);
    cs_high();
    check("dbl_miso0", got, 8'h11);
    check("dbl_miso1", got2, 8'hFF);

    // Reset asserted at bit 4 mid-frame, with a word queued and a prior rx_data.
    cs_low();
    send_bits(8'hF0, 4, got);
    load_tx(8'h99);
    check("pre_rst_ready", tx_ready, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_miso", spi_miso, 1'b0);
    check("mid_rst_oe", spi_miso_oe, 1'b0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_underrun", tx_underrun, 1'b0);
    check("mid_rst_abort", frame_abort, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    wait_clks(2);
    sys_rst_n = 1'b1;
    wait_clks(H);
    check("post_rst_no_frame", busy, 1'b0);
    rxq.delete();
    cs_high();
    cs_low();
    send_bits(8'hC3, 8, got);
    cs_high();
    check("post_rst_rx_cnt", rxq.size(), 1);
    check("post_rst_rx", rx_at(0), 8'hC3);
    check("post_rst_miso", got, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
# spi_responder

Synthesizable SPI responder (slave) that terminates the SPI bus driven by the DPI-based SPI initiator in simulation, and by an external master on hardware. All SPI inputs are oversampled on `sys_clk`. The block uses SPI mode 3: SCK idles high, data is driven on the falling edge and sampled on the rising edge, MSB first. It presents received words and accepts transmit words over a simple parallel handshake to the local logic.

## Interface
- `DATA_W`, 8, word length in bits (≥2)
- `SYNC_STAGES`, 2, synchronizer depth for SCK/CS/MOSI (≥2)
- `TX_DEFAULT`, all ones, word shifted out when no transmit word is queued

- `sys_clk`  in  1  system clock; all logic on rising edge
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low
- `spi_clk_i`  in  1  SPI SCK from initiator
- `spi_cs_i`  in  1  chip select, active-low
- `spi_mosi_i`  in  1  initiator→responder data
- `spi_miso_o`  out  1  responder→initiator data
- `spi_miso_oe_o`  out  1  MISO output enable; high only while selected
- `rx_data_o`  out  DATA_W  last complete received word
- `rx_valid_o`  out  1  one-cycle pulse: `rx_data_o` updated
- `tx_data_i`  in  DATA_W  word to transmit
- `tx_load_i`  in  1  write `tx_data_i` into the holding register
- `tx_ready_o`  out  1  holding register empty
- `tx_underrun_o`  out  1  one-cycle pulse: word start found holding register empty
- `frame_abort_o`  out  1  one-cycle pulse: CS deasserted mid-word
- `busy_o`  out  1  frame in progress (state ACTIVE)

## Operation
- SCK, CS and MOSI each pass through `SYNC_STAGES` flops. SCK and CS edges are detected on the synchronized value against a one-cycle-delayed copy.
- The FSM has two states, IDLE and ACTIVE.
  - IDLE → ACTIVE on a synchronized CS falling edge. This clears `bit_cnt` and sets `spi_miso_oe_o`.
  - ACTIVE → IDLE on a synchronized CS rising edge. This clears `spi_miso_oe_o` and `bit_cnt`.
  - If `bit_cnt` ≠ 0 at that CS rising edge, `frame_abort_o` pulses and the partial RX word is discarded (no `rx_valid_o`).
- SCK falling edge in ACTIVE:
  - If `bit_cnt`==0: load `tx_shift` from the holding register, or from `TX_DEFAULT` if empty (that case pulses `tx_underrun_o`). Drive `spi_miso_o` with the MSB.
  - Otherwise: shift `tx_shift` left and drive the next bit.
- SCK rising edge in ACTIVE:
  - Shift the synchronized MOSI into `rx_shift`.
  - If `bit_cnt`==DATA_W-1: copy `{rx_shift,mosi}` to `rx_data_o`, pulse `rx_valid_o`, and wrap `bit_cnt` to 0. Otherwise increment `bit_cnt`.
- SCK edges in IDLE are ignored.
- There is no RX backpressure. Local logic must consume `rx_data_o` before the next word completes; the register is simply overwritten.
- TX holding register:
  - A `tx_load_i` with `tx_ready_o`=1 stores `tx_data_i` and clears `tx_ready_o` on the next cycle.
  - A load while `tx_ready_o`=0 is ignored.
  - Consumption at word start sets `tx_ready_o` on the next cycle.
  - A load in the same cycle as a word start that finds the register empty does not affect the current word. The current word is `TX_DEFAULT`, the underrun is flagged, and the loaded word is kept for the next word.
  - CS deassert does not flush the holding register.

## Timing
- Reset values:
  - `spi_miso_o`=0, `spi_miso_oe_o`=0
  - `rx_data_o`=0, `rx_valid_o`=0
  - `tx_ready_o`=1, `tx_underrun_o`=0, `frame_abort_o`=0
  - `busy_o`=0, state IDLE
- Reset mid-frame returns to IDLE immediately. The next frame requires a fresh CS falling edge.
- Latency from a raw SCK/CS edge to its effect: `SYNC_STAGES`+1 `sys_clk` cycles. `rx_valid_o`, `tx_underrun_o` and `frame_abort_o` go high on that cycle.
- Constraints on the initiator:
  - SCK high and low phases are each ≥ `SYNC_STAGES`+2 `sys_clk` periods.
  - CS falling edge to first SCK falling edge is ≥ `SYNC_STAGES`+2 periods.
  - Last SCK rising edge to CS rising edge is ≥ `SYNC_STAGES`+2 periods.
- If a CS edge and an SCK edge are detected in the same cycle, the CS edge wins and the SCK edge is dropped.

## Structure
- Package `spi_pkg` holds:
  - the `spi_state_e` enum (IDLE, ACTIVE);
  - the localparam default `DATA_W`;
  - the `TX_DEFAULT` default.
- Sub-module `spi_sync_edge`: parameterized synchronizer plus rise/fall pulse outputs. Instantiated for SCK and CS; MOSI uses synchronizer only.

## Test plan
- Reset released, CS high, SCK toggling → `busy_o`=0, `spi_miso_oe_o`=0, no `rx_valid_o`, `tx_ready_o`=1.
- Load 0xA5; initiator sends 0x3C in one frame → `rx_data_o`=0x3C with a single `rx_valid_o` pulse; MISO bits sampled by the initiator = 0xA5; `tx_ready_o` returns to 1.
- Two back-to-back words with no queued TX, initiator sends 0x01, 0x80 → two `rx_valid_o` pulses, with `rx_data_o` 0x01 then 0x80; initiator reads 0xFF, 0xFF; two `tx_underrun_o` pulses.
- CS raised after 5 bits of a word → `frame_abort_o` pulse, no `rx_valid_o`; the next full frame sending 0x55 yields `rx_data_o`=0x55.
- `tx_load_i` of 0x11 then 0x22 with no frame in between → 0x22 ignored; the next word transmits 0x11.
- `sys_rst_n` asserted at bit 4 mid-frame → all outputs at reset values within the same cycle; the following frame sending 0xC3 is received correctly.
